// File: rtl/mc_controller_ext.sv
`default_nettype none
//------------------------------------------------------------------------------
// mc_controller_ext : multi-cycle MIPS controller (main FSM + ALU decode + PC
// enable) with memory wait states and retired-instruction counter.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal decode locks in TRAP).
// Revision: 1.0
//------------------------------------------------------------------------------
module mc_controller_ext #(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 32,
  parameter int MEM_HS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                irwrite,
  output logic [1:0]          regdst,
  output logic [1:0]          memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic                extop,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic [1:0]          pcsrc,
  output logic                pcen,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count,
  output logic                illegal,
  output logic [4:0]          state_dbg
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,
    DECODE  = 5'd1,
    MEMADR  = 5'd2,
    MEMRD   = 5'd3,
    MEMWB   = 5'd4,
    MEMWR   = 5'd5,
    RTYPEEX = 5'd6,
    RTYPEWB = 5'd7,
    BEQEX   = 5'd8,
    ADDIEX  = 5'd9,
    IMMWB   = 5'd10,
    JEX     = 5'd11,
    BNEEX   = 5'd12,
    ANDIEX  = 5'd13,
    ORIEX   = 5'd14,
    JALEX   = 5'd15,
    JREX    = 5'd16
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    TRAP    = 5'd17
`endif
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);

  localparam logic [FUNCT_W-1:0] FN_JR  = FUNCT_W'(6'b001000);
  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             rdy;
  logic             done;
  logic             pcwrite;
  logic             branch;
  logic             branchn;
  logic             in_trap;
  logic             s_iord, s_memread, s_memwrite, s_irwrite, s_regwrite;
  logic             s_alusrca, s_extop;
  logic [1:0]       s_regdst, s_memtoreg, s_alusrcb, s_pcsrc;
  logic [2:0]       alu3;
  logic [2:0]       rtype_alu;

  // Without handshake the memory is assumed to answer every cycle.
  assign rdy = mem_ready | (MEM_HS == 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      count <= '0;
    end else begin
      state <= next_state;
      if (done) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    rtype_alu = ALU_ADD;
    case (funct)
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: rtype_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    next_state = state;
    done       = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchn    = 1'b0;
    in_trap    = 1'b0;
    s_iord     = 1'b0;
    s_memread  = 1'b0;
    s_memwrite = 1'b0;
    s_irwrite  = 1'b0;
    s_regwrite = 1'b0;
    s_alusrca  = 1'b0;
    s_extop    = 1'b1;
    s_regdst   = 2'b00;
    s_memtoreg = 2'b00;
    s_alusrcb  = 2'b00;
    s_pcsrc    = 2'b00;
    alu3       = ALU_ADD;
    case (state)
      FETCH: begin
        s_memread = 1'b1;
        s_alusrcb = 2'b01;
        s_irwrite = rdy;
        pcwrite   = rdy;
        if (rdy) next_state = DECODE;
      end
      DECODE: begin
        s_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE: begin
            case (funct)
              FN_JR: next_state = JREX;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next_state = RTYPEEX;
              default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                next_state = TRAP;
`else
                next_state = FETCH;
                done       = 1'b1;
`endif
              end
            endcase
          end
          OP_BEQ:  next_state = BEQEX;
          OP_BNE:  next_state = BNEEX;
          OP_ADDI: next_state = ADDIEX;
          OP_ANDI: next_state = ANDIEX;
          OP_ORI:  next_state = ORIEX;
          OP_J:    next_state = JEX;
          OP_JAL:  next_state = JALEX;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            next_state = TRAP;
`else
            next_state = FETCH;
            done       = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        s_alusrca  = 1'b1;
        s_alusrcb  = 2'b10;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        s_iord    = 1'b1;
        s_memread = 1'b1;
        if (rdy) next_state = MEMWB;
      end
      MEMWB: begin
        s_memtoreg = 2'b01;
        s_regwrite = 1'b1;
        next_state = FETCH;
        done       = 1'b1;
      end
      MEMWR: begin
        s_iord     = 1'b1;
        s_memwrite = 1'b1;
        if (rdy) begin
          next_state = FETCH;
          done       = 1'b1;
        end
      end
      RTYPEEX: begin
        s_alusrca  = 1'b1;
        alu3       = rtype_alu;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        s_regdst   = 2'b01;
        s_regwrite = 1'b1;
        next_state = FETCH;
        done       = 1'b1;
      end
      BEQEX, BNEEX: begin
        s_alusrca  = 1'b1;
        alu3       = ALU_SUB;
        s_pcsrc    = 2'b01;
        branch     = (state == BEQEX);
        branchn    = (state == BNEEX);
        next_state = FETCH;
        done       = 1'b1;
      end
      ADDIEX, ANDIEX, ORIEX: begin
        s_alusrca  = 1'b1;
        s_alusrcb  = 2'b10;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        if (state == ANDIEX) begin
          alu3    = ALU_AND;
          s_extop = 1'b0;
        end else if (state == ORIEX) begin
          alu3    = ALU_OR;
          s_extop = 1'b0;
        end
        next_state = IMMWB;
      end
      IMMWB: begin
        s_regwrite = 1'b1;
        next_state = FETCH;
        done       = 1'b1;
      end
      JEX: begin
        s_pcsrc    = 2'b10;
        pcwrite    = 1'b1;
        next_state = FETCH;
        done       = 1'b1;
      end
      JALEX: begin
        s_pcsrc    = 2'b10;
        pcwrite    = 1'b1;
        s_regwrite = 1'b1;
        s_regdst   = 2'b10;
        s_memtoreg = 2'b10;
        next_state = FETCH;
        done       = 1'b1;
      end
      JREX: begin
        s_pcsrc    = 2'b11;
        pcwrite    = 1'b1;
        next_state = FETCH;
        done       = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: begin
        s_extop    = 1'b0;
        in_trap    = 1'b1;
        next_state = TRAP;
      end
`endif
      default: next_state = FETCH;
    endcase
  end

  // Every output is held at 0 while reset is asserted.
  always_comb begin
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    extop       = 1'b0;
    alucontrol  = '0;
    pcsrc       = 2'b00;
    pcen        = 1'b0;
    instr_done  = 1'b0;
    instr_count = '0;
    illegal     = 1'b0;
    state_dbg   = 5'd0;
    if (reset) begin
      iord            = s_iord;
      memread         = s_memread;
      memwrite        = s_memwrite;
      irwrite         = s_irwrite;
      regdst          = s_regdst;
      memtoreg        = s_memtoreg;
      regwrite        = s_regwrite;
      alusrca         = s_alusrca;
      alusrcb         = s_alusrcb;
      extop           = s_extop;
      alucontrol[2:0] = alu3;
      pcsrc           = s_pcsrc;
      pcen            = pcwrite | (branch & zero) | (branchn & ~zero);
      instr_done      = done;
      instr_count     = count;
      illegal         = in_trap;
      state_dbg       = state;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller_ext.sv
`default_nettype none
// Directed bench for mc_controller_ext: one handshaking instance (MEM_HS=1)
// and one instance without wait states (MEM_HS=0, mem_ready held low).
module tb_mc_controller_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rst0 = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mr0 = 1'b0;

  logic        iord, memread, memwrite, irwrite, regwrite, alusrca, extop;
  logic        pcen, instr_done, illegal;
  logic [1:0]  regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instr_count;
  logic [4:0]  state_dbg;

  logic        b_iord, b_memread, b_memwrite, b_irwrite, b_regwrite, b_alusrca, b_extop;
  logic        b_pcen, b_instr_done, b_illegal;
  logic [1:0]  b_regdst, b_memtoreg, b_alusrcb, b_pcsrc;
  logic [2:0]  b_alucontrol;
  logic [31:0] b_instr_count;
  logic [4:0]  b_state_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mc_controller_ext #(.MEM_HS(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop), .alucontrol(alucontrol),
    .pcsrc(pcsrc), .pcen(pcen), .instr_done(instr_done), .instr_count(instr_count),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  mc_controller_ext #(.MEM_HS(0)) dut0 (
    .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mr0), .iord(b_iord), .memread(b_memread), .memwrite(b_memwrite),
    .irwrite(b_irwrite), .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite),
    .alusrca(b_alusrca), .alusrcb(b_alusrcb), .extop(b_extop), .alucontrol(b_alucontrol),
    .pcsrc(b_pcsrc), .pcen(b_pcen), .instr_done(b_instr_done), .instr_count(b_instr_count),
    .illegal(b_illegal), .state_dbg(b_state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH then DECODE with mem_ready high; returns in the execute state.
  task automatic fd(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    tick();
    tick();
  endtask

  initial begin
    // reset held low: outputs forced to zero
    mem_ready = 1'b1;
    op = 6'b100011;
    tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_memread", memread, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_count", instr_count, 0);

    // lw with two wait cycles in FETCH and in MEMRD
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("lw_f0_state", state_dbg, 0);
    chk("lw_f0_memread", memread, 1);
    chk("lw_f0_alusrcb", alusrcb, 1);
    chk("lw_f0_irwrite", irwrite, 0);
    chk("lw_f0_pcen", pcen, 0);
    tick();
    chk("lw_f1_state", state_dbg, 0);
    tick();
    chk("lw_f2_state", state_dbg, 0);
    mem_ready = 1'b1;
    #1;
    chk("lw_f2_irwrite", irwrite, 1);
    chk("lw_f2_pcen", pcen, 1);
    tick();
    chk("lw_dec_state", state_dbg, 1);
    chk("lw_dec_alusrcb", alusrcb, 3);
    tick();
    chk("lw_adr_state", state_dbg, 2);
    chk("lw_adr_alusrca", alusrca, 1);
    chk("lw_adr_alusrcb", alusrcb, 2);
    mem_ready = 1'b0;
    tick();
    chk("lw_rd0_state", state_dbg, 3);
    chk("lw_rd0_iord", iord, 1);
    chk("lw_rd0_memread", memread, 1);
    chk("lw_rd0_regwrite", regwrite, 0);
    tick();
    chk("lw_rd1_state", state_dbg, 3);
    tick();
    chk("lw_rd2_state", state_dbg, 3);
    chk("lw_rd2_done", instr_done, 0);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_state", state_dbg, 4);
    chk("lw_wb_regwrite", regwrite, 1);
    chk("lw_wb_memtoreg", memtoreg, 1);
    chk("lw_wb_done", instr_done, 1);
    chk("lw_wb_count", instr_count, 0);
    tick();
    chk("lw_end_state", state_dbg, 0);
    chk("lw_end_count", instr_count, 1);
    chk("lw_end_done", instr_done, 0);

    // beq taken, then bne not taken / taken with zero toggled
    zero = 1'b1;
    fd(6'b000100, 6'b0);
    chk("beq_state", state_dbg, 8);
    chk("beq_pcen", pcen, 1);
    chk("beq_pcsrc", pcsrc, 1);
    chk("beq_alu", alucontrol, 3'b110);
    chk("beq_done", instr_done, 1);
    tick();
    chk("beq_count", instr_count, 2);
    fd(6'b000101, 6'b0);
    chk("bne_state", state_dbg, 12);
    chk("bne_pcen_z1", pcen, 0);
    zero = 1'b0;
    #1;
    chk("bne_pcen_z0", pcen, 1);
    tick();
    chk("bne_count", instr_count, 3);

    // ori
    fd(6'b001101, 6'b0);
    chk("ori_state", state_dbg, 14);
    chk("ori_extop", extop, 0);
    chk("ori_alu", alucontrol, 3'b001);
    chk("ori_alusrcb", alusrcb, 2);
    chk("ori_regwrite_ex", regwrite, 0);
    tick();
    chk("ori_wb_state", state_dbg, 10);
    chk("ori_wb_regdst", regdst, 0);
    chk("ori_wb_regwrite", regwrite, 1);
    chk("ori_wb_extop", extop, 1);
    chk("ori_wb_done", instr_done, 1);
    tick();
    chk("ori_count", instr_count, 4);

    // jal, jr
    fd(6'b000011, 6'b0);
    chk("jal_state", state_dbg, 15);
    chk("jal_pcen", pcen, 1);
    chk("jal_pcsrc", pcsrc, 2);
    chk("jal_regdst", regdst, 2);
    chk("jal_memtoreg", memtoreg, 2);
    chk("jal_regwrite", regwrite, 1);
    tick();
    fd(6'b000000, 6'b001000);
    chk("jr_state", state_dbg, 16);
    chk("jr_pcsrc", pcsrc, 3);
    chk("jr_pcen", pcen, 1);
    tick();
    chk("jr_count", instr_count, 6);

    // R-type slt
    fd(6'b000000, 6'b101010);
    chk("slt_state", state_dbg, 6);
    chk("slt_alu", alucontrol, 3'b111);
    chk("slt_alusrca", alusrca, 1);
    tick();
    chk("slt_wb_state", state_dbg, 7);
    chk("slt_wb_regdst", regdst, 1);
    chk("slt_wb_regwrite", regwrite, 1);
    tick();
    chk("slt_count", instr_count, 7);

    // illegal opcode
    op = 6'b111111;
    tick();
    chk("ill_dec_state", state_dbg, 1);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("ill_dec_done", instr_done, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("trap_state", state_dbg, 17);
      chk("trap_illegal", illegal, 1);
      chk("trap_count", instr_count, 7);
      chk("trap_pcen", pcen, 0);
      chk("trap_done", instr_done, 0);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
`else
    chk("ill_dec_done", instr_done, 1);
    chk("ill_flag", illegal, 0);
    tick();
    chk("ill_end_state", state_dbg, 0);
    chk("ill_end_count", instr_count, 8);
`endif

    // sw aborted by reset while waiting in MEMWR
    mem_ready = 1'b1;
    fd(6'b101011, 6'b0);
    chk("sw_adr_state", state_dbg, 2);
    mem_ready = 1'b0;
    tick();
    chk("sw_wr0_state", state_dbg, 5);
    chk("sw_wr0_memwrite", memwrite, 1);
    chk("sw_wr0_iord", iord, 1);
    tick();
    chk("sw_wr1_state", state_dbg, 5);
    chk("sw_wr1_done", instr_done, 0);
    reset = 1'b0;
    #1;
    chk("sw_rst_memwrite", memwrite, 0);
    chk("sw_rst_iord", iord, 0);
    chk("sw_rst_done", instr_done, 0);
    chk("sw_rst_count", instr_count, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("sw_rel_state", state_dbg, 0);
    chk("sw_rel_count", instr_count, 0);
    chk("sw_rel_memread", memread, 1);

    // MEM_HS=0 instance: mem_ready low is ignored
    op = 6'b100011;
    funct = 6'b0;
    rst0 = 1'b1;
    #1;
    chk("hs0_f_irwrite", b_irwrite, 1);
    chk("hs0_f_pcen", b_pcen, 1);
    tick();
    chk("hs0_dec_state", b_state_dbg, 1);
    tick();
    chk("hs0_adr_state", b_state_dbg, 2);
    tick();
    chk("hs0_rd_state", b_state_dbg, 3);
    chk("hs0_rd_memread", b_memread, 1);
    tick();
    chk("hs0_wb_state", b_state_dbg, 4);
    chk("hs0_wb_done", b_instr_done, 1);
    tick();
    chk("hs0_lw_count", b_instr_count, 1);
    op = 6'b101011;
    tick();
    tick();
    tick();
    chk("hs0_wr_state", b_state_dbg, 5);
    chk("hs0_wr_done", b_instr_done, 1);
    tick();
    chk("hs0_sw_state", b_state_dbg, 0);
    chk("hs0_sw_count", b_instr_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller_ext.md
Name: mc_controller_ext

Overview:
Parametrised next-generation multi-cycle MIPS controller: main FSM, ALU decoder and PC-enable logic merged into one block.
- Adds bne, andi, ori, jal and jr to the baseline lw/sw/R-type/beq/addi/j set.
- Adds a memory ready handshake (wait states) and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath; all datapath strobes originate here.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUCTL_W, 3, alucontrol width (>=3); upper bits driven 0
CNT_W, 32, instr_count width
MEM_HS, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  OP_W  instruction opcode
funct  in  FUNCT_W  instruction funct
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
iord  out  1  memory address select (1 = aluout)
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  instruction register load
regdst  out  2  00 rt, 01 rd, 10 $31
memtoreg  out  2  00 aluout, 01 data, 10 pc
regwrite  out  1  register file write
alusrca  out  1  0 pc, 1 regA
alusrcb  out  2  00 regB, 01 const 4, 10 imm, 11 imm<<2
extop  out  1  1 sign-extend, 0 zero-extend imm
alucontrol  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
pcsrc  out  2  00 aluresult, 01 aluout, 10 jump target, 11 regA
pcen  out  1  PC register enable
instr_done  out  1  one-cycle pulse on final cycle of each instruction
instr_count  out  CNT_W  retired instructions, wraps
illegal  out  1  illegal instruction flag (see Optional Feature)
state_dbg  out  5  current state encoding

Behaviour:
- Single clock domain; clk, reset as above. Reset low: state=FETCH(0), instr_count=0. All outputs combinational and forced 0 while reset is low.
- Unlisted strobes are 0 in every state. Unlisted alucontrol = add. extop = 1 except ANDIEX/ORIEX.
- pcen = pcwrite | (branch & zero) | (branchn & ~zero).
- States and encodings, with outputs and transitions:
  - FETCH 0: memread=1, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite=pcwrite=mem_ready. Holds in FETCH until mem_ready=1, then -> DECODE.
  - DECODE 1: alusrca=0, alusrcb=11, add. Next state by op:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000): funct 001000 -> JREX; funct add/sub/and/or/slt -> RTYPEEX; other funct = illegal
    - beq 000100 -> BEQEX; bne 000101 -> BNEEX
    - addi 001000 -> ADDIEX; andi 001100 -> ANDIEX; ori 001101 -> ORIEX
    - j 000010 -> JEX; jal 000011 -> JALEX
    - any other op = illegal
  - MEMADR 2: alusrca=1, alusrcb=10, add -> MEMRD (lw) / MEMWR (sw).
  - MEMRD 3: iord=1, memread=1; waits for mem_ready -> MEMWB.
  - MEMWB 4: regdst=00, memtoreg=01, regwrite=1.
  - MEMWR 5: iord=1, memwrite=1, held high until the mem_ready cycle, then -> FETCH.
  - RTYPEEX 6: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> RTYPEWB 7.
  - RTYPEWB 7: regdst=01, memtoreg=00, regwrite=1.
  - BEQEX 8 / BNEEX 12: alusrca=1, alusrcb=00, sub, pcsrc=01; branch (resp. branchn)=1.
  - ADDIEX 9 (add), ANDIEX 13 (and, extop=0), ORIEX 14 (or, extop=0): alusrca=1, alusrcb=10 -> IMMWB 10.
  - IMMWB 10: regdst=00, memtoreg=00, regwrite=1.
  - JEX 11: pcsrc=10, pcwrite=1.
  - JALEX 15: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10. Writes $31 with PC, already incremented by FETCH.
  - JREX 16: pcsrc=11, pcwrite=1.
  - TRAP 17: see Optional Feature.
- Completion:
  - Terminal states MEMWB, MEMWR (on mem_ready), RTYPEWB, BEQEX, BNEEX, IMMWB, JEX, JALEX, JREX -> FETCH.
  - On that transition cycle: instr_done=1 and instr_count += 1 (modulo 2^CNT_W).
- MEM_HS=0: no wait states; FETCH/MEMRD/MEMWR each last exactly 1 cycle.
- Async reset mid-instruction aborts it: no instr_done, counter cleared.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: illegal op/funct in DECODE -> TRAP. TRAP holds forever with all strobes 0 and illegal=1, exits only by reset, no instr_done.
- Undefined: illegal decode -> FETCH as a NOP, with instr_done pulse and count increment; illegal tied 0; TRAP state absent.

Test Plan:
- lw with mem_ready low 2 cycles in both FETCH and MEMRD -> states 0,0,0,1,2,3,3,3,4; regwrite=1, memtoreg=01 only in MEMWB; instr_count 0->1.
- beq then bne with zero=1 -> pcen=1 in BEQEX, pcen=0 in BNEEX; each takes 3 cycles (MEM_HS=0).
- ori op=001101 -> ORIEX has extop=0, alucontrol=001, alusrcb=10; IMMWB regdst=00, regwrite=1.
- jal -> JALEX: pcen=1, pcsrc=10, regdst=10, memtoreg=10, regwrite=1; jr (funct 001000) -> JREX pcsrc=11.
- op=111111 -> with macro: state_dbg=17, illegal=1 held 10 cycles, count frozen; without: back to FETCH, instr_done=1.
- reset driven low during MEMWR wait -> outputs 0 immediately; after release state=0, instr_count=0.
